// File: rtl/fetch_sequencer_pkg.sv
// Shared constants, state encoding and program-slot address table for the fetch run controller.
package fetch_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned CYC_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    STOP
  } state_t;

  function automatic logic [ADDR_W-1:0] prog_addr(input logic [1:0] sel);
    case (sel)
      2'd0:    return ADDR_W'(0);
      2'd1:    return ADDR_W'(32);
      2'd2:    return ADDR_W'(64);
      default: return ADDR_W'(96);
    endcase
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Host/fetch-side signal bundle of the run controller; master = host, slave = sequencer.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = fetch_pkg::ADDR_W,
  parameter int unsigned CYC_W  = fetch_pkg::CYC_W
);
  logic              req;
  logic [1:0]        prog_sel;
  logic              halt_in;
  logic              start;
  logic [ADDR_W-1:0] start_address;
  logic              halt;
  logic              busy;
  logic              done;
  logic              timeout;
  logic              bad_sel;
  logic [CYC_W-1:0]  cycle_count;

  modport master (
    output req, prog_sel, halt_in,
    input  start, start_address, halt, busy, done, timeout, bad_sel, cycle_count
  );

  modport slave (
    input  req, prog_sel, halt_in,
    output start, start_address, halt, busy, done, timeout, bad_sel, cycle_count
  );
endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter; clear has priority over enable.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = (count == '1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch run controller: launches a program slot, runs until HALT or counter saturation, then freezes the PC.
module fetch_sequencer #(
  parameter int unsigned       NUM_PROGS  = 3,
  parameter int unsigned       ADDR_W     = fetch_pkg::ADDR_W,
  parameter int unsigned       CYC_W      = fetch_pkg::CYC_W,
  parameter logic [ADDR_W-1:0] PROG0_ADDR = fetch_pkg::prog_addr(2'd0),
  parameter logic [ADDR_W-1:0] PROG1_ADDR = fetch_pkg::prog_addr(2'd1),
  parameter logic [ADDR_W-1:0] PROG2_ADDR = fetch_pkg::prog_addr(2'd2),
  parameter logic [ADDR_W-1:0] PROG3_ADDR = fetch_pkg::prog_addr(2'd3)
) (
  input logic               clock,
  input logic               reset,
  fetch_sequencer_if.slave  bus
);
  import fetch_pkg::*;

  state_t            state;
  state_t            state_next;
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic              cnt_at_max;
  logic              cnt_last;
  logic              run_end;
  logic              launch_ok;

  always_comb begin
    sel_valid = (32'(bus.prog_sel) < NUM_PROGS);
    case (bus.prog_sel)
      2'd0:    sel_addr = PROG0_ADDR;
      2'd1:    sel_addr = PROG1_ADDR;
      2'd2:    sel_addr = PROG2_ADDR;
      default: sel_addr = PROG3_ADDR;
    endcase
  end

  // The RUN cycle whose increment lands on all-ones is the last one, so STOP shows the saturated count.
  assign cnt_last  = (~bus.cycle_count == CYC_W'(1));
  assign run_end   = bus.halt_in || cnt_last || cnt_at_max;
  assign launch_ok = (state == IDLE) && bus.req && sel_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req && sel_valid) state_next = LAUNCH;
      LAUNCH:  state_next = RUN;
      RUN:     if (run_end) state_next = STOP;
      STOP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.start = (state == LAUNCH);
    bus.halt  = (state == IDLE) || (state == STOP);
    bus.busy  = (state == LAUNCH) || (state == RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.start_address <= '0;
      bus.done          <= 1'b0;
      bus.timeout       <= 1'b0;
      bus.bad_sel       <= 1'b0;
    end else begin
      if (launch_ok) begin
        bus.start_address <= sel_addr;
      end
      bus.done    <= (state == RUN) && bus.halt_in;
      bus.timeout <= (state == RUN) && !bus.halt_in && (cnt_last || cnt_at_max);
      bus.bad_sel <= (state == IDLE) && bus.req && !sel_valid;
    end
  end

  sat_counter #(
    .W (CYC_W)
  ) u_cycle_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == LAUNCH),
    .en     (state == RUN),
    .count  (bus.cycle_count),
    .at_max (cnt_at_max)
  );

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Top-level run controller for the fetch unit: launches a selected program, runs it until the core reports a halt instruction, then freezes the PC.
- Drives fetch's `start`, `start_address` and `halt` inputs.
- Reports busy, done, timeout and an execution cycle count to the testbench/host.
- Sits between the host interface and the fetch/decode stages.

Parameters:
- NUM_PROGS, 3, number of valid program slots (max 4).
- ADDR_W, 7, instruction address width; matches fetch PC width.
- CYC_W, 16, cycle counter width.
- PROG0_ADDR, 7'd0, start address of program 0.
- PROG1_ADDR, 7'd32, start address of program 1.
- PROG2_ADDR, 7'd64, start address of program 2.
- PROG3_ADDR, 7'd96, start address of program 3.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  launch request, sampled in IDLE only.
- prog_sel  in  2  program slot index, sampled with req.
- halt_in  in  1  decoder flag: current instruction is HALT.
- start  out  1  to fetch: load start_address this cycle.
- start_address  out  ADDR_W  to fetch: latched program start address.
- halt  out  1  to fetch: hold PC.
- busy  out  1  high in LAUNCH and RUN.
- done  out  1  one-cycle pulse on normal completion.
- timeout  out  1  one-cycle pulse when the cycle counter saturates in RUN.
- bad_sel  out  1  one-cycle pulse when req arrives with prog_sel >= NUM_PROGS.
- cycle_count  out  CYC_W  RUN cycles of the last/current program.

Behaviour:
- States: IDLE, LAUNCH, RUN, STOP.
- All outputs are registered or decoded from state only; no combinational input-to-output paths.
- Reset: state=IDLE, start=0, halt=1, start_address=0, busy=0, done=0, timeout=0, bad_sel=0, cycle_count=0.
- Reset mid-operation: abort the program immediately, same values as reset. No done pulse.

- IDLE:
  - Outputs: halt=1, start=0.
  - req=1 with valid prog_sel: latch the table address into start_address, go to LAUNCH.
  - req=1 with invalid prog_sel: bad_sel=1 next cycle, stay in IDLE, start_address unchanged.
- LAUNCH (exactly 1 cycle):
  - Outputs: start=1, halt=0, busy=1.
  - cycle_count cleared to 0.
  - Next state RUN. Fetch loads PC=start_address at the end of this cycle.
- RUN:
  - Outputs: start=0, halt=0, busy=1.
  - cycle_count increments by 1 every RUN cycle, including the cycle in which halt_in=1.
  - halt_in=1: go to STOP; done=1 in the STOP cycle.
  - cycle_count reaches all-ones: go to STOP with timeout=1 instead of done; counter saturates and does not wrap.
  - If halt_in=1 and saturation occur in the same cycle, halt_in wins: done=1, timeout=0.
- STOP (exactly 1 cycle):
  - Outputs: halt=1, busy=0, done or timeout pulse.
  - Next state IDLE.
  - cycle_count holds until the next LAUNCH.

- req outside IDLE is ignored; it is not queued.
- halt_in outside RUN is ignored.
- start and halt are never both 1.
- Latency: req sampled at edge N → start=1 during cycle N+1 → first RUN cycle N+2.

Decomposition:
- Package fetch_pkg:
  - ADDR_W and CYC_W constants.
  - state_t enum {IDLE, LAUNCH, RUN, STOP}.
  - Function prog_addr(sel) returning the slot address.
- Sub-module sat_counter:
  - Parameter W.
  - Ports: clock, reset, clear, en, count, at_max.
  - Saturating, clear has priority over en. Instantiated once for cycle_count.

Test Plan:
- Reset → halt=1, busy=0, start=0, cycle_count=0. Reset asserted in RUN → IDLE next cycle, halt=1, no done pulse.
- Launch program 1:
  - Stimulus: req=1, prog_sel=1 at edge 0; halt_in=1 in the 5th RUN cycle.
  - Response: start=1 with start_address=32 in cycle 1; busy high cycles 1–6; done=1 in cycle 7; cycle_count=5; halt=1 from cycle 7.
- Invalid select: prog_sel=3 with NUM_PROGS=3 → bad_sel pulse, state stays IDLE, no start pulse.
- req held high during RUN → no second start pulse. After done and return to IDLE with req still high → new launch.
- Timeout: CYC_W=4, halt_in never asserted → timeout pulse after 15 RUN cycles, cycle_count=15, done=0. Variant with halt_in=1 in that 15th cycle → done=1, timeout=0.
- Back-to-back runs: program 0 then program 2 → second start_address=64; cycle_count cleared in LAUNCH, not carried over.
